// File: rtl/axi_depacketizer.sv
// Receive-side frame parser: turns packetizer byte frames back into 32-bit
// channel-tagged samples and exports header/trailer fields as sideband registers.
module axi_depacketizer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned USER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  output logic [DATA_W-1:0] m_tdata,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [31:0]       pkt_timestamp,
  output logic [7:0]        pkt_channel,
  output logic [7:0]        pkt_sample_cnt,
  output logic [15:0]       pkt_error_flags,
  output logic              pkt_done,
  output logic              pkt_err,
  output logic [1:0]        pkt_err_code
);

  typedef enum logic [2:0] {
    ST_HEADER, ST_TIMESTAMP, ST_CHNID, ST_SAMPLECOUNT,
    ST_PAYLOAD, ST_INFO, ST_DONE, ST_DROP
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         ts_sh_q, ts_sh_d;
  logic [23:0]         word_asm_q, word_asm_d;
  logic [7:0]          words_rx_q, words_rx_d;
  logic [15:0]         flags_sh_q, flags_sh_d;
  logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
  logic [USER_W-1:0]   m_tuser_q, m_tuser_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic                m_tlast_q, m_tlast_d;
  logic [31:0]         pkt_timestamp_q, pkt_timestamp_d;
  logic [7:0]          pkt_channel_q, pkt_channel_d;
  logic [7:0]          pkt_sample_cnt_q, pkt_sample_cnt_d;
  logic [15:0]         pkt_error_flags_q, pkt_error_flags_d;
  logic                pkt_done_q, pkt_done_d;
  logic                pkt_err_q, pkt_err_d;
  logic [1:0]          pkt_err_code_q, pkt_err_code_d;

  logic       accept;
  logic       last_byte;
  logic [7:0] words_rx_inc;
  logic [7:0] hdr_exp;

  // Payload bytes only stall when the output word cannot drain this cycle.
  assign s_tready     = !rst && ((state_q != ST_PAYLOAD) || !m_tvalid_q || m_tready);
  assign accept       = s_tvalid && s_tready;
  assign last_byte    = (byte_idx_q == 2'd3);
  assign words_rx_inc = words_rx_q + 8'd1;

  always_comb begin
    case (byte_idx_q)
      2'd0:    hdr_exp = 8'h44;
      2'd1:    hdr_exp = 8'h51;
      2'd2:    hdr_exp = 8'h41;
      default: hdr_exp = 8'h30;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    byte_idx_d        = byte_idx_q;
    ts_sh_d           = ts_sh_q;
    word_asm_d        = word_asm_q;
    words_rx_d        = words_rx_q;
    flags_sh_d        = flags_sh_q;
    m_tdata_d         = m_tdata_q;
    m_tuser_d         = m_tuser_q;
    m_tvalid_d        = m_tvalid_q && !m_tready;
    m_tlast_d         = m_tlast_q;
    pkt_timestamp_d   = pkt_timestamp_q;
    pkt_channel_d     = pkt_channel_q;
    pkt_sample_cnt_d  = pkt_sample_cnt_q;
    pkt_error_flags_d = pkt_error_flags_q;
    pkt_done_d        = 1'b0;
    pkt_err_d         = 1'b0;
    pkt_err_code_d    = pkt_err_code_q;

    if (accept) begin
      byte_idx_d = byte_idx_q + 2'd1;
      case (state_q)
        ST_HEADER: begin
          if (s_tdata != hdr_exp) begin
            pkt_err_d      = 1'b1;
            pkt_err_code_d = 2'd1;
            state_d        = s_tlast ? ST_HEADER : ST_DROP;
            byte_idx_d     = 2'd0;
          end else if (last_byte) begin
            state_d = ST_TIMESTAMP;
          end
        end
        ST_TIMESTAMP: begin
          ts_sh_d = {s_tdata, ts_sh_q[31:8]};
          if (last_byte) begin
            pkt_timestamp_d = {s_tdata, ts_sh_q[31:8]};
            state_d         = ST_CHNID;
          end
        end
        ST_CHNID: begin
          pkt_channel_d = s_tdata;
          state_d       = ST_SAMPLECOUNT;
        end
        ST_SAMPLECOUNT: begin
          pkt_sample_cnt_d = s_tdata;
          words_rx_d       = 8'd0;
          state_d          = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          case (byte_idx_q)
            2'd0: word_asm_d[7:0]   = s_tdata;
            2'd1: word_asm_d[15:8]  = s_tdata;
            2'd2: word_asm_d[23:16] = s_tdata;
            default: begin
              m_tdata_d  = DATA_W'({s_tdata, word_asm_q});
              m_tuser_d  = USER_W'(pkt_channel_q);
              m_tvalid_d = 1'b1;
              m_tlast_d  = (words_rx_inc == pkt_sample_cnt_q);
              words_rx_d = words_rx_inc;
              if (words_rx_inc == pkt_sample_cnt_q) state_d = ST_INFO;
            end
          endcase
        end
        ST_INFO: begin
          if (byte_idx_q == 2'd0) flags_sh_d[7:0]  = s_tdata;
          if (byte_idx_q == 2'd1) flags_sh_d[15:8] = s_tdata;
          if (last_byte) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (s_tlast && (s_tdata == 8'h00)) begin
            pkt_error_flags_d = flags_sh_q;
            pkt_done_d        = 1'b1;
            state_d           = ST_HEADER;
          end else begin
            pkt_err_d      = 1'b1;
            pkt_err_code_d = 2'd3;
            state_d        = s_tlast ? ST_HEADER : ST_DROP;
          end
        end
        default: begin
          if (s_tlast) state_d = ST_HEADER;
        end
      endcase

      // Truncated frame: anything already emitted stands, the rest is discarded.
      if (s_tlast && (state_q inside {ST_TIMESTAMP, ST_CHNID, ST_SAMPLECOUNT,
                                      ST_PAYLOAD, ST_INFO})) begin
        pkt_err_d      = 1'b1;
        pkt_err_code_d = 2'd2;
        state_d        = ST_HEADER;
      end
      if (state_d != state_q) byte_idx_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_HEADER;
      byte_idx_q        <= 2'd0;
      ts_sh_q           <= 32'd0;
      word_asm_q        <= 24'd0;
      words_rx_q        <= 8'd0;
      flags_sh_q        <= 16'd0;
      m_tdata_q         <= '0;
      m_tuser_q         <= '0;
      m_tvalid_q        <= 1'b0;
      m_tlast_q         <= 1'b0;
      pkt_timestamp_q   <= 32'd0;
      pkt_channel_q     <= 8'd0;
      pkt_sample_cnt_q  <= 8'd0;
      pkt_error_flags_q <= 16'd0;
      pkt_done_q        <= 1'b0;
      pkt_err_q         <= 1'b0;
      pkt_err_code_q    <= 2'd0;
    end else begin
      state_q           <= state_d;
      byte_idx_q        <= byte_idx_d;
      ts_sh_q           <= ts_sh_d;
      word_asm_q        <= word_asm_d;
      words_rx_q        <= words_rx_d;
      flags_sh_q        <= flags_sh_d;
      m_tdata_q         <= m_tdata_d;
      m_tuser_q         <= m_tuser_d;
      m_tvalid_q        <= m_tvalid_d;
      m_tlast_q         <= m_tlast_d;
      pkt_timestamp_q   <= pkt_timestamp_d;
      pkt_channel_q     <= pkt_channel_d;
      pkt_sample_cnt_q  <= pkt_sample_cnt_d;
      pkt_error_flags_q <= pkt_error_flags_d;
      pkt_done_q        <= pkt_done_d;
      pkt_err_q         <= pkt_err_d;
      pkt_err_code_q    <= pkt_err_code_d;
    end
  end

  assign m_tdata         = m_tdata_q;
  assign m_tuser         = m_tuser_q;
  assign m_tvalid        = m_tvalid_q;
  assign m_tlast         = m_tlast_q;
  assign pkt_timestamp   = pkt_timestamp_q;
  assign pkt_channel     = pkt_channel_q;
  assign pkt_sample_cnt  = pkt_sample_cnt_q;
  assign pkt_error_flags = pkt_error_flags_q;
  assign pkt_done        = pkt_done_q;
  assign pkt_err         = pkt_err_q;
  assign pkt_err_code    = pkt_err_code_q;

endmodule

// File: tb/tb_axi_depacketizer.sv
// Scoreboard bench for axi_depacketizer: stimulus queues expected words and
// packet events, a monitor pops and compares them as the DUT presents them.
module tb_axi_depacketizer;

  logic        clk;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic [7:0]  m_tuser;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [31:0] pkt_timestamp;
  logic [7:0]  pkt_channel;
  logic [7:0]  pkt_sample_cnt;
  logic [15:0] pkt_error_flags;
  logic        pkt_done;
  logic        pkt_err;
  logic [1:0]  pkt_err_code;

  axi_depacketizer #(.DATA_W(32), .USER_W(8)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast),
    .pkt_timestamp(pkt_timestamp), .pkt_channel(pkt_channel),
    .pkt_sample_cnt(pkt_sample_cnt), .pkt_error_flags(pkt_error_flags),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .pkt_err_code(pkt_err_code)
  );

  typedef struct { logic [31:0] d; logic [7:0] u; logic l; } wexp_t;
  // kind 0 = pkt_done, 1..3 = pkt_err with that code
  typedef struct { int kind; logic [31:0] ts; logic [15:0] fl; logic [7:0] ch; } eexp_t;

  wexp_t       wq[$];
  eexp_t       eq[$];
  logic [31:0] wds[$];
  logic [7:0]  fb[$];
  int          checks = 0;
  int          errors = 0;
  int          tmode  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // m_tready pattern: 0 = always 1, 1 = toggle every cycle, 2 = held low
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tmode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int n;
    n = 0;
    s_tdata  = b;
    s_tlast  = l;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0h never accepted", b);
        break;
      end
    end
    sync();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic build_frame(input logic [31:0] ts, input logic [7:0] ch, input logic [7:0] n,
                             input logic [15:0] flags, input logic [7:0] done_b);
    fb = {};
    fb.push_back(8'h44); fb.push_back(8'h51); fb.push_back(8'h41); fb.push_back(8'h30);
    for (int i = 0; i < 4; i++) fb.push_back(ts[8*i +: 8]);
    fb.push_back(ch);
    fb.push_back(n);
    foreach (wds[i]) for (int j = 0; j < 4; j++) fb.push_back(wds[i][8*j +: 8]);
    fb.push_back(flags[7:0]); fb.push_back(flags[15:8]);
    fb.push_back(8'h00); fb.push_back(8'h00);
    fb.push_back(done_b);
  endtask

  task automatic send_fb(input int nb, input bit last_tl);
    for (int i = 0; i < nb; i++) send_byte(fb[i], last_tl && (i == nb - 1));
  endtask

  task automatic exp_words(input logic [7:0] ch);
    foreach (wds[i]) wq.push_back('{d: wds[i], u: ch, l: (i == wds.size() - 1)});
  endtask

  task automatic exp_ev(input int kind, input logic [31:0] ts, input logic [15:0] fl,
                        input logic [7:0] ch);
    eq.push_back('{kind: kind, ts: ts, fl: fl, ch: ch});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wq.size() != 0 || eq.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(wq.size() + eq.size()), 32'd0);
    repeat (4) @(negedge clk);
    sync();
  endtask

  task automatic good_frame();
    wds = {32'h04030201, 32'h08070605};
    build_frame(32'hDEADBEEF, 8'h05, 8'd2, 16'h1234, 8'h00);
    exp_words(8'h05);
    exp_ev(0, 32'hDEADBEEF, 16'h1234, 8'h05);
    send_fb(fb.size(), 1'b1);
    drain();
  endtask

  // Monitor: compares every output transfer and every packet event pulse
  initial begin
    wexp_t w;
    eexp_t e;
    int    k;
    forever begin
      @(negedge clk);
      if (!rst && !s_tready) chk("s_tready_stall_cause", 32'(m_tvalid && !m_tready), 32'd1);
      if (m_tvalid && m_tready) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", m_tdata);
        end else begin
          w = wq.pop_front();
          chk("word_data", m_tdata, w.d);
          chk("word_tuser", 32'(m_tuser), 32'(w.u));
          chk("word_tlast", 32'(m_tlast), 32'(w.l));
        end
      end
      if (pkt_done || pkt_err) begin
        chk("done_err_exclusive", 32'(pkt_done && pkt_err), 32'd0);
        k = pkt_done ? 0 : int'(pkt_err_code);
        if (eq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d expected none", k);
        end else begin
          e = eq.pop_front();
          chk("event_kind", 32'(k), 32'(e.kind));
          if (pkt_done && e.kind == 0) begin
            chk("done_timestamp", pkt_timestamp, e.ts);
            chk("done_flags", 32'(pkt_error_flags), 32'(e.fl));
            chk("done_channel", 32'(pkt_channel), 32'(e.ch));
          end
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata", m_tdata, 32'd0);
    chk("rst_m_tuser", 32'(m_tuser), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_timestamp", pkt_timestamp, 32'd0);
    chk("rst_channel", 32'(pkt_channel), 32'd0);
    chk("rst_sample_cnt", 32'(pkt_sample_cnt), 32'd0);
    chk("rst_flags", 32'(pkt_error_flags), 32'd0);
    chk("rst_done", 32'(pkt_done), 32'd0);
    chk("rst_err", 32'(pkt_err), 32'd0);
    chk("rst_err_code", 32'(pkt_err_code), 32'd0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_tready", 32'(s_tready), 32'd1);
    sync();

    // Good frame, sink always ready
    good_frame();
    chk("ts_after_good", pkt_timestamp, 32'hDEADBEEF);
    chk("flags_after_good", 32'(pkt_error_flags), 32'h1234);
    chk("cnt_after_good", 32'(pkt_sample_cnt), 32'd2);

    // Same frame with toggling sink
    tmode = 1;
    good_frame();
    tmode = 0;
    sync();

    // Header byte 2 corrupted: error code 1, remainder dropped, then recovery
    wds = {32'hAABBCCDD};
    build_frame(32'h11223344, 8'h03, 8'd1, 16'h0001, 8'h00);
    fb[2] = 8'h99;
    exp_ev(1, 32'h0, 16'h0, 8'h0);
    send_fb(fb.size(), 1'b1);
    drain();
    wds = {32'h0BADF00D};
    build_frame(32'h01020304, 8'h06, 8'd1, 16'h00FF, 8'h00);
    exp_words(8'h06);
    exp_ev(0, 32'h01020304, 16'h00FF, 8'h06);
    send_fb(fb.size(), 1'b1);
    drain();

    // N=4, tlast on 3rd byte of word 1: word 0 emitted, error code 2
    wds = {32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD};
    build_frame(32'h55667788, 8'h0A, 8'd4, 16'h0000, 8'h00);
    wq.push_back('{d: 32'h44332211, u: 8'h0A, l: 1'b0});
    exp_ev(2, 32'h0, 16'h0, 8'h0);
    send_fb(17, 1'b1);
    drain();
    good_frame();

    // N=0 means 256 words, tlast only on the last one
    wds = {};
    for (int k = 0; k < 256; k++) wds.push_back({8'(k), 8'hA5, 8'(255 - k), 8'h5A});
    build_frame(32'hCAFE0000, 8'h7E, 8'd0, 16'hBEEF, 8'h00);
    exp_words(8'h7E);
    exp_ev(0, 32'hCAFE0000, 16'hBEEF, 8'h7E);
    send_fb(fb.size(), 1'b1);
    drain();

    // Bad done byte: error code 3, flags keep previous packet's value
    wds = {32'h13579BDF};
    build_frame(32'h2468ACE0, 8'h01, 8'd1, 16'h5555, 8'h7F);
    exp_words(8'h01);
    exp_ev(3, 32'h0, 16'h0, 8'h0);
    send_fb(fb.size(), 1'b1);
    drain();
    chk("flags_kept_on_bad_done", 32'(pkt_error_flags), 32'hBEEF);
    chk("ts_of_bad_done_frame", pkt_timestamp, 32'h2468ACE0);

    // Reset mid-payload with a word stuck in the output register
    tmode = 2;
    sync();
    sync();
    wds = {32'h11111111, 32'h22222222};
    build_frame(32'h9ABCDEF0, 8'h09, 8'd2, 16'h0000, 8'h00);
    send_fb(14, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("stalled_m_tvalid", 32'(m_tvalid), 32'd1);
    chk("stalled_m_tdata", m_tdata, 32'h11111111);
    chk("stalled_m_tuser", 32'(m_tuser), 32'h09);
    chk("stalled_s_tready", 32'(s_tready), 32'd0);
    sync();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_m_tdata", m_tdata, 32'd0);
    chk("midrst_m_tuser", 32'(m_tuser), 32'd0);
    chk("midrst_timestamp", pkt_timestamp, 32'd0);
    chk("midrst_channel", 32'(pkt_channel), 32'd0);
    sync();
    rst   = 1'b0;
    tmode = 0;
    sync();
    sync();
    good_frame();

    chk("final_word_queue", 32'(wq.size()), 32'd0);
    chk("final_event_queue", 32'(eq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_depacketizer.md
# axi_depacketizer

Receive-side counterpart of the DAQ byte-stream packetizer. It parses framed byte packets and restores 32-bit sample words with channel tagging. Packet header fields and error flags are extracted to sideband registers, and malformed frames are dropped with an error pulse. It sits at the host/loopback end of the capture link, feeding sample consumers and monitoring logic.

## Interface
- DATA_W, 32: output sample width; must be 32.
- USER_W, 8: tuser width on m_axi_if; carries channel_id.
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset; synchronous, active-high.
- s_axi_if  axi_if.slave  tdata[7:0], tvalid, tready, tlast  byte stream in packetizer frame format.
- m_axi_if  axi_if.master  tdata[31:0], tuser[7:0], tvalid, tready, tlast  reassembled samples.
- pkt_timestamp  out  32  timestamp of the last fully parsed header.
- pkt_channel  out  8  channel_id byte of the current/last packet.
- pkt_sample_cnt  out  8  sample-count byte of the current/last packet (0 means 256).
- pkt_error_flags  out  16  info bytes 0..1 of the last completed packet.
- pkt_done  out  1  one-cycle pulse after a good packet completes.
- pkt_err  out  1  one-cycle pulse on a framing error.
- pkt_err_code  out  2  valid with pkt_err: 1 = bad header, 2 = early tlast, 3 = bad trailer.

## Operation
- Frame format, byte order on the wire:
  - header 44 51 41 30;
  - timestamp 4 bytes, LSB first;
  - channel_id 1 byte;
  - sample_cnt N, 1 byte;
  - N×4 payload bytes, each word LSB first;
  - info 4 bytes (flags[7:0], flags[15:8], 00, 00);
  - done byte 00 with tlast=1.
- States: ST_HEADER, ST_TIMESTAMP, ST_CHNID, ST_SAMPLECOUNT, ST_PAYLOAD, ST_INFO, ST_DONE, ST_DROP.
  - Reset state is ST_HEADER.
  - A 2-bit byte_idx clears on every state change.
- ST_HEADER:
  - Each accepted byte is compared against the expected header byte for byte_idx.
  - A mismatch pulses pkt_err with code 1. The block then goes to ST_DROP, or stays in ST_HEADER if that byte carried tlast.
  - After the 4th matching byte, go to ST_TIMESTAMP.
- ST_TIMESTAMP: bytes are shifted into a shadow register. pkt_timestamp loads when the 4th byte is accepted, then go to ST_CHNID.
- ST_CHNID: the byte loads pkt_channel, then go to ST_SAMPLECOUNT.
- ST_SAMPLECOUNT: the byte loads pkt_sample_cnt and clears the 8-bit words_rx counter, then go to ST_PAYLOAD.
- ST_PAYLOAD:
  - Bytes assemble into word_asm[8*idx +: 8].
  - On the 4th byte, word_asm plus the incoming byte load the output register:
    - m_tvalid=1;
    - m_tuser=pkt_channel;
    - m_tlast=1 iff this is word N, checked as (words_rx+1) mod 256 == pkt_sample_cnt;
    - words_rx increments.
  - After word N, go to ST_INFO.
- ST_INFO: bytes 0..1 load the flags shadow and bytes 2..3 are ignored. After the 4th byte, go to ST_DONE.
- ST_DONE:
  - A byte 00 with tlast=1 loads pkt_error_flags from the shadow and pulses pkt_done, then go to ST_HEADER.
  - Any other value, or tlast=0: pkt_err with code 3.
    - With tlast=1, go to ST_HEADER.
    - With tlast=0, go to ST_DROP.
- ST_DROP: accept and discard bytes until a byte with tlast is accepted, then go to ST_HEADER. No error pulse is generated here.
- Early tlast: tlast on any accepted byte in ST_TIMESTAMP through ST_INFO.
  - Response: pkt_err code 2, go to ST_HEADER, partial word_asm discarded.
  - Words already emitted stand. No synthetic m_tlast is generated.
  - If the early tlast lands on a payload word's 4th byte, that word is still emitted, with m_tlast reflecting the count rule.
- Counter arithmetic: words_rx is an 8-bit counter that wraps, so N=0 yields 256 words.

## Timing
- s_tready:
  - 0 while rst is high;
  - otherwise 1 in every state except ST_PAYLOAD;
  - in ST_PAYLOAD, !m_tvalid || m_tready (combinational from m_tready).
- A byte is consumed only on s_tvalid && s_tready. The output path has no s_tvalid→m_tvalid combinational path.
- Latency: m_tvalid rises the cycle after the 4th payload byte is accepted.
  - The output register holds data, tuser and tlast stable until m_tvalid && m_tready.
  - A new word may load in the same cycle the previous one drains, giving full byte-rate throughput.
- pkt_done, pkt_err and the sideband loads are registered and appear the cycle after the triggering byte.
  - pkt_done and pkt_err are mutually exclusive.
- Reset values:
  - m_tvalid, m_tlast, m_tdata and m_tuser are 0.
  - All pkt_* outputs are 0.
  - State is ST_HEADER, and byte_idx and words_rx are 0.
  - Reset mid-packet discards everything, including a pending output word.

## Test plan
- Good frame, N=2, channel 05, ts 0xDEADBEEF, flags 0x1234, m_tready=1. Expected response:
  - words 0x04030201 and 0x08070605 with tuser 05, tlast on the second;
  - pkt_timestamp=DEADBEEF and pkt_error_flags=1234;
  - one pkt_done pulse.
- Same frame with m_tready toggling 1/0 every cycle: no word lost or duplicated, s_tready stalls only in ST_PAYLOAD, and the data order is preserved.
- Header byte 2 = 0x99 mid-frame: pkt_err code 1, then the rest of the frame is dropped until tlast, and a following good frame parses with pkt_done.
- tlast on the 3rd byte of payload word 1 with N=4: word 0 is emitted, pkt_err code 2, and the next frame parses correctly.
- N=0 frame: 256 words emitted, tlast only on word 256, then pkt_done.
- Done byte 0x7F with tlast: pkt_err code 3 and no pkt_done. Assert rst mid-payload: outputs return to 0 and the next frame parses correctly.
